// File: rtl/sdram_line_pkg.sv
// sdram_line_pkg: shared types and derived sizes for the SDRAM line port.
//   - state_e : burst sequencer states
//   - linewords()/cntwidth() : halfwords per line and word-counter width,
//     both derived from OFFSETWIDTH (log2 bytes per line)
//   - SDRAM address field widths (bank/row/column)
package sdram_line_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RDCMD   = 3'd1,
    RDBURST = 3'd2,
    WRCMD   = 3'd3,
    WRBURST = 3'd4
  } state_e;

  localparam int BANKW = 2;
  localparam int ROWW  = 13;
  localparam int COLW  = 9;

  // A line of 2**off bytes holds 2**(off-1) halfwords.
  function automatic int linewords(input int off);
    return 1 << (off - 1);
  endfunction

  // off bits span 0..2**(off-1) inclusive, so a full line count fits.
  function automatic int cntwidth(input int off);
    return off;
  endfunction

  localparam int DEF_OFFSETWIDTH = 5;
  localparam int LINEWORDS       = linewords(DEF_OFFSETWIDTH);
  localparam int CNTWIDTH        = cntwidth(DEF_OFFSETWIDTH);

endpackage

// File: rtl/sdram_line_port_if.sv
// sdram_line_port_if: all request/data/command signals between the cache,
// the line port and the SDRAM controller.
//   slave  : the line port's view (cache requests in, burst commands out)
//   master : the environment's view (cache + SDRAM controller)
interface sdram_line_port_if #(parameter int ADDRWIDTH = 24);
  // cache side
  logic                 readreq;
  logic [ADDRWIDTH-1:0] readaddr;
  logic                 writereq;
  logic [ADDRWIDTH-1:0] writeaddr;
  logic [15:0]          data_to_ram;
  logic                 write;
  logic                 writeready;
  logic [15:0]          data_from_ram;
  logic                 read;
  logic                 readready;
  logic [1:0]           req_busy;
  logic                 overrun_err;
  // SDRAM controller side
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic [15:0]          wr_data;
  logic                 wr_data_ready;
  logic [15:0]          rd_data;
  logic                 rd_data_valid;

  modport slave (
    input  readreq, readaddr, writereq, writeaddr, data_to_ram, write, read,
           cmd_ready, wr_data_ready, rd_data, rd_data_valid,
    output writeready, data_from_ram, readready, req_busy, overrun_err,
           cmd_valid, cmd_write, cmd_addr, wr_data
  );

  modport master (
    output readreq, readaddr, writereq, writeaddr, data_to_ram, write, read,
           cmd_ready, wr_data_ready, rd_data, rd_data_valid,
    input  writeready, data_from_ram, readready, req_busy, overrun_err,
           cmd_valid, cmd_write, cmd_addr, wr_data
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst_n : clock, async active-low reset
//   push_i/din_i : write side (push while full is dropped)
//   pop_i        : read side (pop while empty is ignored)
//   dout_o       : head entry, 0 when empty
//   count_o      : occupancy 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNTW-1:0]  count_o
);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wptr_q, rptr_q;
  logic [CNTW-1:0]  count_q, count_d;
  logic             full, empty, push_ok, pop_ok;

  assign full    = (count_q == CNTW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push_i & ~full;
  assign pop_ok  = pop_i & ~empty;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= (wptr_q == PTRW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= (rptr_q == PTRW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = empty ? '0 : mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/sdram_line_port.sv
// sdram_line_port: bridges the cache controller to the SDRAM controller.
// Holds one line-fill and one eviction request, buffers one line each way,
// and issues whole-line burst commands, one outstanding at a time.
//   clock, reset_n : sole clock, async active-low reset
//   bus (slave)    : cache requests/data and SDRAM burst command/data
module sdram_line_port
  import sdram_line_pkg::*;
#(
  parameter int OFFSETWIDTH = 5,
  parameter int ADDRWIDTH   = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  sdram_line_port_if.slave  bus
);
  localparam int WORDS = linewords(OFFSETWIDTH);
  localparam int CNTW  = cntwidth(OFFSETWIDTH);
  localparam logic [CNTW-1:0]      WORDS_C   = CNTW'(WORDS);
  localparam logic [CNTW-1:0]      LAST_C    = CNTW'(WORDS - 1);
  localparam logic [ADDRWIDTH-1:0] ADDR_MASK = ~ADDRWIDTH'((1 << OFFSETWIDTH) - 1);

  state_e               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 rd_busy_q, wr_busy_q, overrun_q;
  logic [ADDRWIDTH-1:0] rd_addr_q, wr_addr_q;
  logic                 rd_take, wr_take, rd_done, wr_done;
  logic                 r_push, r_empty, w_pop, w_line_full;
  logic [CNTW-1:0]      r_count, w_count;
  logic [15:0]          w_head;

  assign rd_take = bus.readreq  & ~rd_busy_q;
  assign wr_take = bus.writereq & ~wr_busy_q;

  assign r_empty     = (r_count == '0);
  assign w_line_full = (w_count == WORDS_C);
  assign r_push      = (state_q == RDBURST) & bus.rd_data_valid;
  assign w_pop       = (state_q == WRBURST) & bus.wr_data_ready;

  sync_fifo #(.WIDTH(16), .DEPTH(WORDS), .CNTW(CNTW)) u_rfifo (
    .clk(clock), .rst_n(reset_n),
    .push_i(r_push), .din_i(bus.rd_data), .pop_i(bus.read),
    .dout_o(bus.data_from_ram), .count_o(r_count)
  );

  sync_fifo #(.WIDTH(16), .DEPTH(WORDS), .CNTW(CNTW)) u_wfifo (
    .clk(clock), .rst_n(reset_n),
    .push_i(bus.write), .din_i(bus.data_to_ram), .pop_i(w_pop),
    .dout_o(w_head), .count_o(w_count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_done = 1'b0;
    wr_done = 1'b0;
    case (state_q)
      // Requests arriving this cycle count as busy so the command can
      // go out the cycle right after the request edge. The write side
      // also waits for the read FIFO to drain, keeping fills in order.
      IDLE: begin
        if ((rd_busy_q | bus.readreq) && r_empty)
          state_d = RDCMD;
        else if ((wr_busy_q | bus.writereq) && w_line_full && r_empty)
          state_d = WRCMD;
      end
      RDCMD: if (bus.cmd_ready) begin state_d = RDBURST; cnt_d = '0; end
      WRCMD: if (bus.cmd_ready) begin state_d = WRBURST; cnt_d = '0; end
      RDBURST: if (bus.rd_data_valid) begin
        cnt_d = (cnt_q == WORDS_C) ? cnt_q : cnt_q + 1'b1;
        if (cnt_q == LAST_C) begin rd_done = 1'b1; state_d = IDLE; end
      end
      WRBURST: if (bus.wr_data_ready) begin
        cnt_d = (cnt_q == WORDS_C) ? cnt_q : cnt_q + 1'b1;
        if (cnt_q == LAST_C) begin wr_done = 1'b1; state_d = IDLE; end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_busy_q <= 1'b0;
      wr_busy_q <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rd_take) begin
        rd_busy_q <= 1'b1;
        rd_addr_q <= bus.readaddr & ADDR_MASK;
      end else if (rd_done) begin
        rd_busy_q <= 1'b0;
      end
      if (wr_take) begin
        wr_busy_q <= 1'b1;
        wr_addr_q <= bus.writeaddr & ADDR_MASK;
      end else if (wr_done) begin
        wr_busy_q <= 1'b0;
      end
      if ((bus.readreq & rd_busy_q) | (bus.writereq & wr_busy_q) |
          (bus.rd_data_valid & (state_q != RDBURST)))
        overrun_q <= 1'b1;
    end
  end

  assign bus.writeready  = ~w_line_full;
  assign bus.readready   = ~r_empty;
  assign bus.req_busy    = {wr_busy_q, rd_busy_q};
  assign bus.overrun_err = overrun_q;
  assign bus.cmd_valid   = (state_q == RDCMD) | (state_q == WRCMD);
  assign bus.cmd_write   = (state_q == WRCMD);
  assign bus.cmd_addr    = (state_q == RDCMD) ? rd_addr_q :
                           (state_q == WRCMD) ? wr_addr_q : '0;
  assign bus.wr_data     = (state_q == WRBURST) ? w_head : 16'h0000;
endmodule

// File: tb/tb_sdram_line_port.sv
// tb_sdram_line_port: randomized scenario bench for sdram_line_port.
// Expected data comes from queues modelling each line buffer; expected
// addresses are the request address with the line offset cleared.
module tb_sdram_line_port;
  localparam int OFF   = 5;
  localparam int AW    = 24;
  localparam int WORDS = 1 << (OFF - 1);
  localparam logic [AW-1:0] AMASK = ~AW'((1 << OFF) - 1);

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;

  sdram_line_port_if #(.ADDRWIDTH(AW)) bus ();

  sdram_line_port #(.OFFSETWIDTH(OFF), .ADDRWIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    bus.readreq = 0; bus.readaddr = '0; bus.writereq = 0; bus.writeaddr = '0;
    bus.data_to_ram = '0; bus.write = 0; bus.read = 0; bus.cmd_ready = 0;
    bus.wr_data_ready = 0; bus.rd_data = '0; bus.rd_data_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    step(); step();
    total++; if (bus.writeready !== 1'b1) begin bad++; $display("FAIL rst_writeready got=%0h exp=1", bus.writeready); end
    total++; if (bus.readready !== 1'b0) begin bad++; $display("FAIL rst_readready got=%0h exp=0", bus.readready); end
    total++; if (bus.req_busy !== 2'b00) begin bad++; $display("FAIL rst_req_busy got=%0h exp=0", bus.req_busy); end
    total++; if (bus.overrun_err !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%0h exp=0", bus.overrun_err); end
    total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_cmd_valid got=%0h exp=0", bus.cmd_valid); end
    total++; if (bus.cmd_addr !== '0) begin bad++; $display("FAIL rst_cmd_addr got=%0h exp=0", bus.cmd_addr); end
    total++; if (bus.data_from_ram !== 16'h0) begin bad++; $display("FAIL rst_data_from_ram got=%0h exp=0", bus.data_from_ram); end
    total++; if (bus.wr_data !== 16'h0) begin bad++; $display("FAIL rst_wr_data got=%0h exp=0", bus.wr_data); end
    reset_n = 1;
    step();
  endtask

  task automatic test_line_fill(input logic [AW-1:0] addr, input bit seq_data, input bit gaps);
    logic [15:0] q[$];
    logic [15:0] w;
    bit r;
    int n;
    bus.readreq = 1; bus.readaddr = addr; bus.cmd_ready = 1;
    step();
    bus.readreq = 0; bus.readaddr = AW'($urandom);
    total++; if (bus.cmd_valid !== 1'b1) begin bad++; $display("FAIL fill_cmd_valid got=%0h exp=1", bus.cmd_valid); end
    total++; if (bus.cmd_write !== 1'b0) begin bad++; $display("FAIL fill_cmd_write got=%0h exp=0", bus.cmd_write); end
    total++; if (bus.cmd_addr !== (addr & AMASK)) begin bad++; $display("FAIL fill_cmd_addr got=%0h exp=%0h", bus.cmd_addr, addr & AMASK); end
    total++; if (bus.req_busy[0] !== 1'b1) begin bad++; $display("FAIL fill_busy_set got=%0h exp=1", bus.req_busy[0]); end
    step();
    total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL fill_cmd_drop got=%0h exp=0", bus.cmd_valid); end
    for (int i = 0; i < WORDS; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      w = seq_data ? 16'hA000 + 16'(i) : 16'($urandom);
      bus.rd_data = w; bus.rd_data_valid = 1; q.push_back(w);
      step();
      bus.rd_data_valid = 0;
      if (i == 0) begin
        total++; if (bus.readready !== 1'b1) begin bad++; $display("FAIL fill_readready got=%0h exp=1", bus.readready); end
        total++; if (bus.data_from_ram !== q[0]) begin bad++; $display("FAIL fill_first_word got=%0h exp=%0h", bus.data_from_ram, q[0]); end
      end
      if (i == WORDS - 2) begin
        total++; if (bus.req_busy[0] !== 1'b1) begin bad++; $display("FAIL fill_busy_hold got=%0h exp=1", bus.req_busy[0]); end
      end
    end
    total++; if (bus.req_busy[0] !== 1'b0) begin bad++; $display("FAIL fill_busy_clear got=%0h exp=0", bus.req_busy[0]); end
    n = 0;
    while (q.size() > 0 && n < 200) begin
      r = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      total++; if (bus.readready !== 1'b1 || bus.data_from_ram !== q[0]) begin bad++; $display("FAIL fill_data got=%0h/%0h exp=1/%0h", bus.readready, bus.data_from_ram, q[0]); end
      bus.read = r;
      step();
      bus.read = 0;
      if (r) void'(q.pop_front());
      n++;
    end
    total++; if (bus.readready !== 1'b0 || bus.data_from_ram !== 16'h0) begin bad++; $display("FAIL fill_empty got=%0h/%0h exp=0/0", bus.readready, bus.data_from_ram); end
    bus.cmd_ready = 0;
  endtask

  // Waits (bounded) for a write command, checks it, then drains the line.
  task automatic drain_write(input logic [AW-1:0] addr, input bit gaps, inout logic [15:0] q[$]);
    bit r;
    int n;
    bus.cmd_ready = 0;
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 4) begin step(); n++; end
    total++; if (bus.cmd_valid !== 1'b1) begin bad++; $display("FAIL wr_cmd_timeout got=%0h exp=1", bus.cmd_valid); end
    total++; if (bus.cmd_write !== 1'b1) begin bad++; $display("FAIL wr_cmd_write got=%0h exp=1", bus.cmd_write); end
    total++; if (bus.cmd_addr !== (addr & AMASK)) begin bad++; $display("FAIL wr_cmd_addr got=%0h exp=%0h", bus.cmd_addr, addr & AMASK); end
    bus.cmd_ready = 1;
    step();
    bus.cmd_ready = 0;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      r = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.wr_data_ready = r;
      total++; if (bus.wr_data !== q[0]) begin bad++; $display("FAIL wr_data got=%0h exp=%0h", bus.wr_data, q[0]); end
      step();
      if (r) void'(q.pop_front());
      n++;
    end
    bus.wr_data_ready = 0;
    total++; if (bus.req_busy[1] !== 1'b0) begin bad++; $display("FAIL wr_busy_clear got=%0h exp=0", bus.req_busy[1]); end
    total++; if (bus.wr_data !== 16'h0 || bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL wr_idle got=%0h/%0h exp=0/0", bus.wr_data, bus.cmd_valid); end
    total++; if (bus.writeready !== 1'b1) begin bad++; $display("FAIL wr_writeready got=%0h exp=1", bus.writeready); end
  endtask

  task automatic test_eviction(input logic [AW-1:0] addr, input bit gaps);
    logic [15:0] q[$];
    logic [15:0] w;
    bus.writereq = 1; bus.writeaddr = addr;
    step();
    bus.writereq = 0;
    total++; if (bus.req_busy[1] !== 1'b1) begin bad++; $display("FAIL ev_busy_set got=%0h exp=1", bus.req_busy[1]); end
    // Outside a write burst, wr_data_ready must not drain anything.
    bus.wr_data_ready = !gaps;
    for (int i = 0; i < WORDS; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      w = 16'($urandom);
      bus.data_to_ram = w; bus.write = 1; q.push_back(w);
      step();
      bus.write = 0;
      if (i < WORDS - 1) begin
        total++; if (bus.cmd_valid !== 1'b0 || bus.wr_data !== 16'h0) begin bad++; $display("FAIL ev_early got=%0h/%0h exp=0/0", bus.cmd_valid, bus.wr_data); end
      end
    end
    bus.wr_data_ready = 0;
    total++; if (bus.writeready !== 1'b0) begin bad++; $display("FAIL ev_writeready got=%0h exp=0", bus.writeready); end
    drain_write(addr, gaps, q);
  endtask

  task automatic test_simultaneous();
    logic [15:0] wq[$];
    logic [15:0] rq[$];
    logic [15:0] w;
    logic [AW-1:0] ra, wa;
    int n;
    ra = AW'($urandom); wa = AW'($urandom);
    for (int i = 0; i < WORDS; i++) begin
      w = 16'($urandom); bus.data_to_ram = w; bus.write = 1; wq.push_back(w);
      step();
    end
    bus.write = 0;
    bus.readreq = 1; bus.readaddr = ra; bus.writereq = 1; bus.writeaddr = wa; bus.cmd_ready = 1;
    step();
    bus.readreq = 0; bus.writereq = 0;
    total++; if (bus.cmd_valid !== 1'b1 || bus.cmd_write !== 1'b0) begin bad++; $display("FAIL sim_read_first got=%0h/%0h exp=1/0", bus.cmd_valid, bus.cmd_write); end
    total++; if (bus.cmd_addr !== (ra & AMASK)) begin bad++; $display("FAIL sim_rd_addr got=%0h exp=%0h", bus.cmd_addr, ra & AMASK); end
    total++; if (bus.req_busy !== 2'b11) begin bad++; $display("FAIL sim_busy got=%0h exp=3", bus.req_busy); end
    step();
    bus.cmd_ready = 0;
    for (int i = 0; i < WORDS; i++) begin
      w = 16'($urandom); bus.rd_data = w; bus.rd_data_valid = 1; rq.push_back(w);
      step();
    end
    bus.rd_data_valid = 0;
    total++; if (bus.req_busy !== 2'b10) begin bad++; $display("FAIL sim_busy_after_rd got=%0h exp=2", bus.req_busy); end
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL sim_wr_held got=%0h exp=0", bus.cmd_valid); end
      step();
    end
    n = 0;
    while (rq.size() > 0 && n < 100) begin
      total++; if (bus.data_from_ram !== rq[0] || bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL sim_rd_data got=%0h/%0h exp=%0h/0", bus.data_from_ram, bus.cmd_valid, rq[0]); end
      bus.read = 1;
      step();
      bus.read = 0;
      void'(rq.pop_front());
      n++;
    end
    drain_write(wa, 1'b0, wq);
    total++; if (bus.req_busy !== 2'b00) begin bad++; $display("FAIL sim_busy_end got=%0h exp=0", bus.req_busy); end
  endtask

  task automatic test_backpressure();
    logic [15:0] q[$];
    logic [15:0] w;
    logic [AW-1:0] a;
    a = AW'($urandom);
    bus.cmd_ready = 0; bus.readreq = 1; bus.readaddr = a;
    step();
    bus.readreq = 0;
    for (int c = 0; c < 5; c++) begin
      total++; if (bus.cmd_valid !== 1'b1 || bus.cmd_write !== 1'b0) begin bad++; $display("FAIL bp_cmd got=%0h/%0h exp=1/0", bus.cmd_valid, bus.cmd_write); end
      total++; if (bus.cmd_addr !== (a & AMASK)) begin bad++; $display("FAIL bp_addr got=%0h exp=%0h", bus.cmd_addr, a & AMASK); end
      if (c == 0) begin
        total++; if (bus.overrun_err !== 1'b0) begin bad++; $display("FAIL bp_overrun_pre got=%0h exp=0", bus.overrun_err); end
      end
      if (c == 1) begin bus.readreq = 1; bus.readaddr = ~a; end
      step();
      bus.readreq = 0;
    end
    total++; if (bus.overrun_err !== 1'b1) begin bad++; $display("FAIL bp_overrun got=%0h exp=1", bus.overrun_err); end
    bus.cmd_ready = 1;
    step();
    bus.cmd_ready = 0;
    for (int i = 0; i < WORDS; i++) begin
      w = 16'($urandom); bus.rd_data = w; bus.rd_data_valid = 1; q.push_back(w);
      step();
    end
    bus.rd_data_valid = 0;
    while (q.size() > 0) begin
      total++; if (bus.data_from_ram !== q[0]) begin bad++; $display("FAIL bp_data got=%0h exp=%0h", bus.data_from_ram, q[0]); end
      bus.read = 1;
      step();
      bus.read = 0;
      void'(q.pop_front());
    end
    total++; if (bus.req_busy !== 2'b00 || bus.overrun_err !== 1'b1) begin bad++; $display("FAIL bp_end got=%0h/%0h exp=0/1", bus.req_busy, bus.overrun_err); end
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < WORDS; i++) begin
      bus.data_to_ram = 16'($urandom); bus.write = 1;
      step();
    end
    bus.write = 0;
    total++; if (bus.writeready !== 1'b0) begin bad++; $display("FAIL rm_pre_writeready got=%0h exp=0", bus.writeready); end
    bus.readreq = 1; bus.readaddr = AW'($urandom); bus.cmd_ready = 1;
    step();
    bus.readreq = 0;
    step();
    bus.cmd_ready = 0;
    for (int i = 0; i < 7; i++) begin
      bus.rd_data = 16'($urandom); bus.rd_data_valid = 1;
      step();
    end
    bus.rd_data_valid = 0;
    total++; if (bus.readready !== 1'b1) begin bad++; $display("FAIL rm_pre_readready got=%0h exp=1", bus.readready); end
    #2 reset_n = 0;
    #1;
    total++; if (bus.readready !== 1'b0 || bus.writeready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%0h/%0h exp=0/1", bus.readready, bus.writeready); end
    total++; if (bus.req_busy !== 2'b00 || bus.overrun_err !== 1'b0) begin bad++; $display("FAIL rm_busy_ovr got=%0h/%0h exp=0/0", bus.req_busy, bus.overrun_err); end
    total++; if (bus.cmd_valid !== 1'b0 || bus.data_from_ram !== 16'h0 || bus.wr_data !== 16'h0) begin bad++; $display("FAIL rm_outputs got=%0h/%0h/%0h exp=0/0/0", bus.cmd_valid, bus.data_from_ram, bus.wr_data); end
    step(); step();
    reset_n = 1;
    step();
    // A clean fill afterwards shows the sequencer came back idle and empty.
    test_line_fill(AW'($urandom), 1'b0, 1'b0);
  endtask

  task automatic test_fifo_edges();
    logic [15:0] q[$];
    logic [15:0] w;
    logic [AW-1:0] a;
    total++; if (bus.readready !== 1'b0 || bus.data_from_ram !== 16'h0) begin bad++; $display("FAIL fe_empty got=%0h/%0h exp=0/0", bus.readready, bus.data_from_ram); end
    bus.read = 1;
    step();
    bus.read = 0;
    total++; if (bus.readready !== 1'b0 || bus.data_from_ram !== 16'h0) begin bad++; $display("FAIL fe_empty_pop got=%0h/%0h exp=0/0", bus.readready, bus.data_from_ram); end
    total++; if (bus.overrun_err !== 1'b0) begin bad++; $display("FAIL fe_overrun_pre got=%0h exp=0", bus.overrun_err); end
    bus.rd_data = 16'hBEEF; bus.rd_data_valid = 1;
    step();
    bus.rd_data_valid = 0;
    total++; if (bus.overrun_err !== 1'b1) begin bad++; $display("FAIL fe_stray_rd got=%0h exp=1", bus.overrun_err); end
    total++; if (bus.readready !== 1'b0) begin bad++; $display("FAIL fe_stray_dropped got=%0h exp=0", bus.readready); end
    for (int i = 0; i < WORDS + 1; i++) begin
      w = 16'($urandom); bus.data_to_ram = w; bus.write = 1;
      if (q.size() < WORDS) q.push_back(w);
      step();
    end
    bus.write = 0;
    total++; if (bus.writeready !== 1'b0) begin bad++; $display("FAIL fe_full got=%0h exp=0", bus.writeready); end
    a = AW'($urandom);
    bus.writereq = 1; bus.writeaddr = a;
    step();
    bus.writereq = 0;
    drain_write(a, 1'b0, q);
    total++; if (q.size() != 0) begin bad++; $display("FAIL fe_drain_left got=%0d exp=0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_line_fill(24'h012345, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) test_line_fill(AW'($urandom), 1'b0, 1'b1);
    test_eviction(24'h00FFE0, 1'b0);
    for (int k = 0; k < 3; k++) test_eviction(AW'($urandom), 1'b1);
    test_simultaneous();
    test_backpressure();
    test_reset_midburst();
    test_fifo_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
